// File: rtl/mux_scan_nby1_if.sv
`default_nettype none
// ============================================================================
// Module   : mux_scan_nby1_if
// Brief    : Sample output stream (data bit, channel index, wrap) with
//            valid/ready handshake.
// Revision : 1.0
// ============================================================================
interface mux_scan_nby1_if #(
    parameter int SEL_W = 4
);
    logic             Z;
    logic [SEL_W-1:0] ch_out;
    logic             out_valid;
    logic             out_ready;
    logic             wrap;

    modport master (
        output Z,
        output ch_out,
        output out_valid,
        output wrap,
        input  out_ready
    );

    modport slave (
        input  Z,
        input  ch_out,
        input  out_valid,
        input  wrap,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/mux_scan_nby1.sv
`default_nettype none
// ============================================================================
// Module   : mux_scan_nby1
// Brief    : Registered N:1 bit multiplexer with manual/auto-scan channel
//            sequencer and a stallable valid/ready output stage.
// Revision : 1.0
// ============================================================================
module mux_scan_nby1 #(
    parameter int NUM_CH  = 16,
    parameter int SEL_W   = $clog2(NUM_CH),
    parameter int DWELL_W = 4
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               en,
    input  wire logic               mode,
    input  wire logic               sel_load,
    input  wire logic [SEL_W-1:0]   sel_in,
    input  wire logic [DWELL_W-1:0] dwell,
    input  wire logic [NUM_CH-1:0]  i,
    mux_scan_nby1_if.master         o_bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MANUAL = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    localparam logic [SEL_W-1:0] c_LAST_CH = SEL_W'(NUM_CH - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [SEL_W-1:0]   r_ptr;
    logic [DWELL_W-1:0] r_dwell_cnt;
    logic               r_z;
    logic [SEL_W-1:0]   r_ch;
    logic               r_valid;
    logic               r_wrap;

    logic               w_take;
    logic [DWELL_W-1:0] w_eff_m1;
    logic               w_dwell_done;
    logic               w_ptr_last;
    logic               w_scan_wrap;
    logic [SEL_W-1:0]   w_sel_clamped;

    always_comb begin
        w_state_nxt = ST_IDLE;
        if (en) begin
            w_state_nxt = mode ? ST_SCAN : ST_MANUAL;
        end
    end

    assign w_take        = (r_state != ST_IDLE) && (!r_valid || o_bus.out_ready);
    assign w_eff_m1      = (dwell == '0) ? '0 : (dwell - DWELL_W'(1));
    // >= rather than == so a dwell shortened mid-channel still advances
    assign w_dwell_done  = (r_dwell_cnt >= w_eff_m1);
    assign w_ptr_last    = (r_ptr == c_LAST_CH);
    assign w_scan_wrap   = (r_state == ST_SCAN) && w_dwell_done && w_ptr_last;
    assign w_sel_clamped = (sel_in > c_LAST_CH) ? c_LAST_CH : sel_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_dwell_cnt <= '0;
            r_z         <= 1'b0;
            r_ch        <= '0;
            r_valid     <= 1'b0;
            r_wrap      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (w_take) begin
                r_z     <= i[r_ptr];
                r_ch    <= r_ptr;
                r_valid <= 1'b1;
                r_wrap  <= w_scan_wrap;
            end else if (r_valid && o_bus.out_ready) begin
                r_valid <= 1'b0;
            end

            // Load wins over scan advance; the take above still used the old pointer
            if (sel_load) begin
                r_ptr       <= w_sel_clamped;
                r_dwell_cnt <= '0;
            end else if ((w_state_nxt == ST_SCAN) && (r_state != ST_SCAN)) begin
                r_dwell_cnt <= '0;
            end else if (w_take && (r_state == ST_SCAN)) begin
                if (w_dwell_done) begin
                    r_dwell_cnt <= '0;
                    r_ptr       <= w_ptr_last ? '0 : (r_ptr + SEL_W'(1));
                end else begin
                    r_dwell_cnt <= r_dwell_cnt + DWELL_W'(1);
                end
            end
        end
    end

    assign o_bus.Z         = r_z;
    assign o_bus.ch_out    = r_ch;
    assign o_bus.out_valid = r_valid;
    assign o_bus.wrap      = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_mux_scan_nby1.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_scan_nby1
// Brief    : Scoreboard bench for a 16-channel and a 12-channel instance.
// Revision : 1.0
// ============================================================================
module tb_mux_scan_nby1;

    typedef struct packed {
        logic       z;
        logic [3:0] ch;
        logic       wrap;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en_a = 1'b0;
    logic        en_b = 1'b0;
    logic        mode = 1'b0;
    logic        sel_load = 1'b0;
    logic [3:0]  sel_in = '0;
    logic [3:0]  dwell = '0;
    logic [15:0] i_a = '0;
    logic [11:0] i_b = '0;
    logic        rdy = 1'b1;

    logic [15:0] pat_a;
    logic [11:0] pat_b;

    exp_t q_a[$];
    exp_t q_b[$];
    int   total = 0;
    int   bad   = 0;

    mux_scan_nby1_if #(.SEL_W(4)) u_if_a ();
    mux_scan_nby1_if #(.SEL_W(4)) u_if_b ();

    assign u_if_a.out_ready = rdy;
    assign u_if_b.out_ready = rdy;

    mux_scan_nby1 #(.NUM_CH(16), .DWELL_W(4)) u_dut_a (
        .clk(clk), .rst(rst), .en(en_a), .mode(mode), .sel_load(sel_load),
        .sel_in(sel_in), .dwell(dwell), .i(i_a), .o_bus(u_if_a)
    );

    mux_scan_nby1 #(.NUM_CH(12), .DWELL_W(4)) u_dut_b (
        .clk(clk), .rst(rst), .en(en_b), .mode(mode), .sel_load(sel_load),
        .sel_in(sel_in), .dwell(dwell), .i(i_b), .o_bus(u_if_b)
    );

    always #5 clk = ~clk;

    // Monitors: a handshake seen at the negedge is accepted at the next posedge
    always @(negedge clk) begin : m_a
        exp_t e;
        exp_t g;
        if (u_if_a.out_valid && u_if_a.out_ready) begin
            total++;
            g = {u_if_a.Z, u_if_a.ch_out, u_if_a.wrap};
            if (q_a.size() == 0) begin
                bad++;
                $display("FAIL mon_a: unexpected sample z=%0d ch=%0d wrap=%0d", g.z, g.ch, g.wrap);
            end else begin
                e = q_a.pop_front();
                if (g !== e) begin
                    bad++;
                    $display("FAIL mon_a: got z=%0d ch=%0d wrap=%0d expected z=%0d ch=%0d wrap=%0d",
                             g.z, g.ch, g.wrap, e.z, e.ch, e.wrap);
                end
            end
        end
    end

    always @(negedge clk) begin : m_b
        exp_t e;
        exp_t g;
        if (u_if_b.out_valid && u_if_b.out_ready) begin
            total++;
            g = {u_if_b.Z, u_if_b.ch_out, u_if_b.wrap};
            if (q_b.size() == 0) begin
                bad++;
                $display("FAIL mon_b: unexpected sample z=%0d ch=%0d wrap=%0d", g.z, g.ch, g.wrap);
            end else begin
                e = q_b.pop_front();
                if (g !== e) begin
                    bad++;
                    $display("FAIL mon_b: got z=%0d ch=%0d wrap=%0d expected z=%0d ch=%0d wrap=%0d",
                             g.z, g.ch, g.wrap, e.z, e.ch, e.wrap);
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    task automatic push_a(input int ch, input bit w);
        q_a.push_back({pat_a[ch], 4'(ch), w});
    endtask

    task automatic push_b(input int ch, input bit w);
        q_b.push_back({pat_b[ch], 4'(ch), w});
    endtask

    task automatic drain();
        int n = 0;
        while (((q_a.size() + q_b.size()) != 0) && (n < 40)) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("drain_queue_empty", q_a.size() + q_b.size(), 0);
    endtask

    task automatic load(input int s);
        @(posedge clk); #1;
        sel_in   = 4'(s);
        sel_load = 1'b1;
        @(posedge clk); #1;
        sel_load = 1'b0;
    endtask

    // Enable held across m rising edges yields exactly m samples
    task automatic run(input bit use_b, input int m);
        @(posedge clk); #1;
        if (use_b) en_b = 1'b1; else en_a = 1'b1;
        repeat (m) @(posedge clk);
        #1;
        en_a = 1'b0;
        en_b = 1'b0;
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_valid_a", u_if_a.out_valid, 0);
        chk("rst_z_a",     u_if_a.Z,         0);
        chk("rst_ch_a",    u_if_a.ch_out,    0);
        chk("rst_wrap_a",  u_if_a.wrap,      0);
        chk("rst_valid_b", u_if_b.out_valid, 0);
        chk("rst_ch_b",    u_if_b.ch_out,    0);

        // Manual channel 5
        mode  = 1'b0;
        dwell = 4'd0;
        load(5);
        i_a = 16'h0020; pat_a = i_a;
        for (int k = 0; k < 4; k++) push_a(5, 1'b0);
        run(1'b0, 4);
        i_a = 16'hFFDF; pat_a = i_a;
        for (int k = 0; k < 3; k++) push_a(5, 1'b0);
        run(1'b0, 3);

        // Scan, dwell 1, full lap plus one
        mode  = 1'b1;
        dwell = 4'd1;
        i_a = 16'hA5C3; pat_a = i_a;
        load(0);
        for (int k = 0; k < 17; k++) push_a(k % 16, (k % 16) == 15);
        run(1'b0, 17);

        // Dwell 3, then dwell 0 behaving as 1
        dwell = 4'd3;
        load(0);
        for (int k = 0; k < 9; k++) push_a(k / 3, 1'b0);
        run(1'b0, 9);
        dwell = 4'd0;
        for (int k = 3; k < 6; k++) push_a(k, 1'b0);
        run(1'b0, 3);

        // Backpressure at channel 7
        dwell = 4'd1;
        load(0);
        for (int k = 0; k < 15; k++) push_a(k, 1'b0);
        @(posedge clk); #1;
        en_a = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (c == 9)  rdy  = 1'b0;
            if (c == 14) rdy  = 1'b1;
            if (c == 20) en_a = 1'b0;
            if (c >= 10 && c <= 13) begin
                @(negedge clk);
                chk("stall_valid", u_if_a.out_valid, 1);
                chk("stall_ch",    u_if_a.ch_out,    7);
                chk("stall_z",     u_if_a.Z,         pat_a[7]);
            end
        end
        drain();

        // 12-channel instance: clamp, wrap at 11, load vs advance
        i_b = 12'h9B6; pat_b = i_b;
        mode = 1'b0;
        load(14);
        push_b(11, 1'b0);
        run(1'b1, 1);
        mode = 1'b1;
        push_b(11, 1'b1);
        push_b(0, 1'b0);
        push_b(1, 1'b0);
        run(1'b1, 3);
        push_b(2, 1'b0);
        push_b(3, 1'b0);
        push_b(6, 1'b0);
        push_b(7, 1'b0);
        @(posedge clk); #1;
        en_b = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        sel_in   = 4'd6;
        sel_load = 1'b1;
        @(posedge clk); #1;
        sel_load = 1'b0;
        @(posedge clk); #1;
        en_b = 1'b0;
        drain();

        // Async reset while a sample is pending (instance A pointer is 6)
        rdy = 1'b0;
        @(posedge clk); #1;
        en_a = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        en_a = 1'b0;
        @(negedge clk);
        chk("pend_valid", u_if_a.out_valid, 1);
        chk("pend_ch",    u_if_a.ch_out,    6);
        chk("pend_z",     u_if_a.Z,         1);
        #1 rst = 1'b1;
        #1;
        chk("arst_valid", u_if_a.out_valid, 0);
        chk("arst_z",     u_if_a.Z,         0);
        chk("arst_ch",    u_if_a.ch_out,    0);
        chk("arst_wrap",  u_if_a.wrap,      0);
        #1 rst = 1'b0;
        rdy = 1'b1;
        for (int k = 0; k < 3; k++) push_a(k, 1'b0);
        run(1'b0, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
